// File: rtl/nco_sweep_ctrl.sv
// Frequency-sweep sequencer for an NCO: steps the phase increment from phi_start
// by phi_step, holding each step for a dwell time, and repeats the sweep n_sweeps times.
//
// state | meaning
// IDLE  | outputs quiet, waiting for start
// SWEEP | driving the NCO with the current step increment
// DONE  | one-cycle done pulse after a finite run, then back to IDLE
module nco_sweep_ctrl #(
  parameter int PHI_W = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             abort,
  input  logic [PHI_W-1:0] phi_start,
  input  logic [PHI_W-1:0] phi_step,
  input  logic [CNT_W-1:0] n_steps,
  input  logic [CNT_W-1:0] dwell,
  input  logic [7:0]       n_sweeps,
  output logic [PHI_W-1:0] phi_inc_o,
  output logic             clken_o,
  output logic             busy,
  output logic             sweep_trig,
  output logic             done
);

  typedef enum logic [1:0] {IDLE, SWEEP, DONE} state_t;

  state_t state, state_nxt;

  logic [PHI_W-1:0] phi_start_q, phi_start_nxt;
  logic [PHI_W-1:0] phi_step_q, phi_step_nxt;
  logic [CNT_W-1:0] steps_m1_q, steps_m1_nxt;
  logic [CNT_W-1:0] dwell_m1_q, dwell_m1_nxt;
  logic [7:0]       n_sweeps_q, n_sweeps_nxt;
  logic [CNT_W-1:0] dwell_cnt, dwell_cnt_nxt;
  logic [CNT_W-1:0] step_cnt, step_cnt_nxt;
  logic [7:0]       sweep_cnt, sweep_cnt_nxt;

  logic [PHI_W-1:0] phi_nxt;
  logic             clken_nxt, busy_nxt, trig_nxt, done_nxt;

  logic             load;
  logic             sweep_end;
  logic             more_sweeps;
  logic [7:0]       sweeps_inc;
  logic [CNT_W-1:0] dwell_in_m1;

  assign load        = (state == IDLE) && start && !abort;
  assign sweep_end   = (dwell_cnt == '0) && (step_cnt == '0);
  // completed-sweep count saturates so continuous runs never wrap it
  assign sweeps_inc  = (sweep_cnt == 8'hFF) ? 8'hFF : sweep_cnt + 8'd1;
  assign more_sweeps = (n_sweeps_q == 8'd0) || (sweeps_inc < n_sweeps_q);
  // dwell of 0 behaves as a single-cycle hold
  assign dwell_in_m1 = (dwell == '0) ? '0 : dwell - CNT_W'(1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      phi_start_q <= '0;
      phi_step_q  <= '0;
      steps_m1_q  <= '0;
      dwell_m1_q  <= '0;
      n_sweeps_q  <= '0;
      dwell_cnt   <= '0;
      step_cnt    <= '0;
      sweep_cnt   <= '0;
      phi_inc_o   <= '0;
      clken_o     <= 1'b0;
      busy        <= 1'b0;
      sweep_trig  <= 1'b0;
      done        <= 1'b0;
    end else begin
      state       <= state_nxt;
      phi_start_q <= phi_start_nxt;
      phi_step_q  <= phi_step_nxt;
      steps_m1_q  <= steps_m1_nxt;
      dwell_m1_q  <= dwell_m1_nxt;
      n_sweeps_q  <= n_sweeps_nxt;
      dwell_cnt   <= dwell_cnt_nxt;
      step_cnt    <= step_cnt_nxt;
      sweep_cnt   <= sweep_cnt_nxt;
      phi_inc_o   <= phi_nxt;
      clken_o     <= clken_nxt;
      busy        <= busy_nxt;
      sweep_trig  <= trig_nxt;
      done        <= done_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (load) state_nxt = (n_steps == '0) ? DONE : SWEEP;
      SWEEP: begin
        if (abort)                          state_nxt = IDLE;
        else if (sweep_end && !more_sweeps) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    phi_start_nxt = phi_start_q;
    phi_step_nxt  = phi_step_q;
    steps_m1_nxt  = steps_m1_q;
    dwell_m1_nxt  = dwell_m1_q;
    n_sweeps_nxt  = n_sweeps_q;
    dwell_cnt_nxt = dwell_cnt;
    step_cnt_nxt  = step_cnt;
    sweep_cnt_nxt = sweep_cnt;
    phi_nxt       = '0;
    clken_nxt     = 1'b0;
    busy_nxt      = 1'b0;
    trig_nxt      = 1'b0;
    done_nxt      = 1'b0;

    if (load) begin
      phi_start_nxt = phi_start;
      phi_step_nxt  = phi_step;
      steps_m1_nxt  = n_steps - CNT_W'(1);
      dwell_m1_nxt  = dwell_in_m1;
      n_sweeps_nxt  = n_sweeps;
      dwell_cnt_nxt = dwell_in_m1;
      step_cnt_nxt  = n_steps - CNT_W'(1);
      sweep_cnt_nxt = '0;
    end

    case (state_nxt)
      SWEEP: begin
        clken_nxt = 1'b1;
        busy_nxt  = 1'b1;
        if (state == IDLE) begin
          phi_nxt  = phi_start;
          trig_nxt = 1'b1;
        end else if (dwell_cnt != '0) begin
          dwell_cnt_nxt = dwell_cnt - CNT_W'(1);
          phi_nxt       = phi_inc_o;
        end else if (step_cnt != '0) begin
          step_cnt_nxt  = step_cnt - CNT_W'(1);
          dwell_cnt_nxt = dwell_m1_q;
          phi_nxt       = phi_inc_o + phi_step_q;
        end else begin
          // back-to-back sweep: reload without a gap cycle
          step_cnt_nxt  = steps_m1_q;
          dwell_cnt_nxt = dwell_m1_q;
          sweep_cnt_nxt = sweeps_inc;
          phi_nxt       = phi_start_q;
          trig_nxt      = 1'b1;
        end
      end
      DONE:    done_nxt = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_nco_sweep_ctrl.sv
// Directed bench for nco_sweep_ctrl: table of sweep runs with per-cycle expected
// outputs, plus hand-written abort, continuous-mode and reset sequences.
module tb_nco_sweep_ctrl;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [31:0] phi_start = '0;
  logic [31:0] phi_step = '0;
  logic [15:0] n_steps = '0;
  logic [15:0] dwell = '0;
  logic [7:0]  n_sweeps = '0;
  logic [31:0] phi_inc_o;
  logic        clken_o, busy, sweep_trig, done;

  nco_sweep_ctrl #(.PHI_W(32), .CNT_W(16)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .abort      (abort),
    .phi_start  (phi_start),
    .phi_step   (phi_step),
    .n_steps    (n_steps),
    .dwell      (dwell),
    .n_sweeps   (n_sweeps),
    .phi_inc_o  (phi_inc_o),
    .clken_o    (clken_o),
    .busy       (busy),
    .sweep_trig (sweep_trig),
    .done       (done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] phi;
    logic        clken;
    logic        busy;
    logic        trig;
    logic        done;
  } obs_t;

  typedef struct {
    logic [31:0] ps;
    logic [31:0] st;
    logic [15:0] ns;
    logic [15:0] dw;
    logic [7:0]  nsw;
    bit          perturb;
    int          first;
    int          len;
  } vec_t;

  localparam obs_t ZERO = '0;

  obs_t exp_tab[$];
  vec_t cases[$];
  int   n_pass = 0;
  int   n_total = 0;

  function automatic obs_t mk(input logic [31:0] p, input logic c, input logic b,
                              input logic t, input logic d);
    obs_t o;
    o.phi = p; o.clken = c; o.busy = b; o.trig = t; o.done = d;
    return o;
  endfunction

  function automatic obs_t obs();
    return mk(phi_inc_o, clken_o, busy, sweep_trig, done);
  endfunction

  function automatic void add(input logic [31:0] p, input logic c, input logic b,
                              input logic t, input logic d);
    exp_tab.push_back(mk(p, c, b, t, d));
  endfunction

  function automatic void begin_case(input logic [31:0] ps, input logic [31:0] st,
                                     input logic [15:0] ns, input logic [15:0] dw,
                                     input logic [7:0] nsw, input bit perturb);
    vec_t v;
    v.ps = ps; v.st = st; v.ns = ns; v.dw = dw; v.nsw = nsw; v.perturb = perturb;
    v.first = exp_tab.size();
    v.len = 0;
    cases.push_back(v);
  endfunction

  function automatic void end_case();
    cases[cases.size()-1].len = exp_tab.size() - cases[cases.size()-1].first;
  endfunction

  task automatic check(input string nm, input int cyc, input obs_t got, input obs_t want);
    n_total++;
    if (got === want) n_pass++;
    else $display("FAIL %s cyc %0d: got phi=%h clken=%b busy=%b trig=%b done=%b, expected phi=%h clken=%b busy=%b trig=%b done=%b",
                  nm, cyc, got.phi, got.clken, got.busy, got.trig, got.done,
                  want.phi, want.clken, want.busy, want.trig, want.done);
  endtask

  task automatic check_int(input string nm, input int got, input int want);
    n_total++;
    if (got == want) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", nm, got, want);
  endtask

  task automatic set_cfg(input logic [31:0] ps, input logic [31:0] st, input logic [15:0] ns,
                         input logic [15:0] dw, input logic [7:0] nsw);
    phi_start = ps; phi_step = st; n_steps = ns; dwell = dw; n_sweeps = nsw;
  endtask

  // Start at edge T; the k-th negedge after T shows cycle T+k.
  task automatic run_case(input int ci);
    vec_t v;
    v = cases[ci];
    @(negedge clk);
    set_cfg(v.ps, v.st, v.ns, v.dw, v.nsw);
    start = 1'b1;
    for (int k = 0; k < v.len; k++) begin
      @(negedge clk);
      check($sformatf("vec%0d", ci), k + 1, obs(), exp_tab[v.first + k]);
      if (k == 0) start = 1'b0;
      if (v.perturb && k == 2) begin
        start = 1'b1;
        set_cfg(32'hDEADBEEF, 32'h1234, 16'd1, 16'd9, 8'd7);
      end
      if (v.perturb && k == 3) start = 1'b0;
    end
  endtask

  initial begin
    int bad;

    // vec0: 4 steps x dwell 2, one sweep; mid-run start and config change ignored
    begin_case(32'h0053E2D6, 32'h100, 16'd4, 16'd2, 8'd1, 1'b1);
    add(32'h0053E2D6, 1, 1, 1, 0); add(32'h0053E2D6, 1, 1, 0, 0);
    add(32'h0053E3D6, 1, 1, 0, 0); add(32'h0053E3D6, 1, 1, 0, 0);
    add(32'h0053E4D6, 1, 1, 0, 0); add(32'h0053E4D6, 1, 1, 0, 0);
    add(32'h0053E5D6, 1, 1, 0, 0); add(32'h0053E5D6, 1, 1, 0, 0);
    add(32'h0, 0, 0, 0, 1);        add(32'h0, 0, 0, 0, 0);
    end_case();
    // vec1: three sweeps of 2 steps, dwell 0 acts as 1
    begin_case(32'h1000, 32'h10, 16'd2, 16'd0, 8'd3, 1'b0);
    add(32'h1000, 1, 1, 1, 0); add(32'h1010, 1, 1, 0, 0);
    add(32'h1000, 1, 1, 1, 0); add(32'h1010, 1, 1, 0, 0);
    add(32'h1000, 1, 1, 1, 0); add(32'h1010, 1, 1, 0, 0);
    add(32'h0, 0, 0, 0, 1);    add(32'h0, 0, 0, 0, 0);
    end_case();
    // vec2: increment wraps past 2^32
    begin_case(32'hFFFFFFF0, 32'h20, 16'd2, 16'd1, 8'd1, 1'b0);
    add(32'hFFFFFFF0, 1, 1, 1, 0); add(32'h00000010, 1, 1, 0, 0);
    add(32'h0, 0, 0, 0, 1);        add(32'h0, 0, 0, 0, 0);
    end_case();
    // vec3: n_steps = 0 goes straight to DONE
    begin_case(32'h1234, 32'h1, 16'd0, 16'd3, 8'd2, 1'b0);
    add(32'h0, 0, 0, 0, 1); add(32'h0, 0, 0, 0, 0);
    end_case();
    // vec4: negative step, two sweeps
    begin_case(32'h100, 32'hFFFFFFC0, 16'd3, 16'd1, 8'd2, 1'b0);
    add(32'h100, 1, 1, 1, 0); add(32'h0C0, 1, 1, 0, 0); add(32'h080, 1, 1, 0, 0);
    add(32'h100, 1, 1, 1, 0); add(32'h0C0, 1, 1, 0, 0); add(32'h080, 1, 1, 0, 0);
    add(32'h0, 0, 0, 0, 1);   add(32'h0, 0, 0, 0, 0);
    end_case();

    repeat (2) @(posedge clk);
    #1 check("in_reset", 0, obs(), ZERO);
    @(negedge clk) reset_n = 1'b1;
    @(negedge clk) check("after_reset", 0, obs(), ZERO);

    for (int ci = 0; ci < cases.size(); ci++) run_case(ci);

    // start and abort together in IDLE: abort wins
    @(negedge clk);
    set_cfg(32'h0053E2D6, 32'h100, 16'd4, 16'd2, 8'd1);
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    check("start_abort", 1, obs(), ZERO);
    @(negedge clk) check("start_abort", 2, obs(), ZERO);

    // continuous run, abort in sweep 5 step 1 (6 cycles per sweep)
    @(negedge clk);
    set_cfg(32'h1000, 32'h40, 16'd3, 16'd2, 8'd0);
    start = 1'b1;
    for (int k = 1; k <= 33; k++) begin
      @(negedge clk);
      if (k == 1) start = 1'b0;
      if (k == 6)  check("cont_last", k, obs(), mk(32'h1080, 1, 1, 0, 0));
      if (k == 7)  check("cont_nogap", k, obs(), mk(32'h1000, 1, 1, 1, 0));
      if (k == 31) check("cont_sweep5", k, obs(), mk(32'h1000, 1, 1, 1, 0));
      if (k == 33) begin
        check("cont_step1", k, obs(), mk(32'h1040, 1, 1, 0, 0));
        abort = 1'b1;
      end
    end
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (k == 1) abort = 1'b0;
      check("cont_abort", 33 + k, obs(), ZERO);
    end

    // continuous run longer than 255 sweeps: sweep counter must not end the run
    @(negedge clk);
    set_cfg(32'h7, 32'h1, 16'd1, 16'd0, 8'd0);
    start = 1'b1;
    bad = 0;
    for (int k = 1; k <= 300; k++) begin
      @(negedge clk);
      if (k == 1) start = 1'b0;
      if (obs() !== mk(32'h7, 1, 1, 1, 0)) bad++;
    end
    check_int("cont_300_sweeps_bad_cycles", bad, 0);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("cont300_abort", 0, obs(), ZERO);

    // asynchronous reset mid-step, then clean restart
    @(negedge clk);
    set_cfg(32'h0053E2D6, 32'h100, 16'd4, 16'd2, 8'd1);
    start = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (k == 1) start = 1'b0;
    end
    check("pre_reset", 4, obs(), mk(32'h0053E3D6, 1, 1, 0, 0));
    #2 reset_n = 1'b0;
    #1 check("async_reset", 0, obs(), ZERO);
    @(negedge clk);
    check("held_reset", 0, obs(), ZERO);
    reset_n = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      check("post_reset_quiet", k, obs(), ZERO);
    end
    run_case(0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/nco_sweep_ctrl.md
NCO_SWEEP_CTRL -- requirements
Module: nco_sweep_ctrl

Interface
REQ-001 The block SHALL have parameter PHI_W, default 32, which sets the phase-increment word width.
REQ-002 The block SHALL have parameter CNT_W, default 16, which sets the step-count and dwell counter width.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all logic SHALL be clocked on its rising edge.
REQ-004 The block SHALL have port reset_n, input, 1 bit: reset, asynchronous, active-low.
REQ-005 The block SHALL have port start, input, 1 bit: request to begin a sweep run, sampled only in IDLE.
REQ-006 The block SHALL have port abort, input, 1 bit: terminate the run immediately.
REQ-007 The block SHALL have port phi_start, input, PHI_W bits: first phase increment of each sweep.
REQ-008 The block SHALL have port phi_step, input, PHI_W bits: per-step increment delta, two's complement.
REQ-009 The block SHALL have port n_steps, input, CNT_W bits: steps per sweep.
REQ-010 The block SHALL have port dwell, input, CNT_W bits: cycles each step is held.
REQ-011 The block SHALL have port n_sweeps, input, 8 bits: sweeps per run, where 0 means continuous.
REQ-012 The block SHALL have port phi_inc_o, output, PHI_W bits: phase increment driven to the NCO phi_inc_i.
REQ-013 The block SHALL have port clken_o, output, 1 bit: NCO clock enable.
REQ-014 The block SHALL have port busy, output, 1 bit: run in progress.
REQ-015 The block SHALL have port sweep_trig, output, 1 bit: one-cycle pulse on the first cycle of every sweep.
REQ-016 The block SHALL have port done, output, 1 bit: one-cycle pulse when a finite run completes normally.

Function
REQ-017 The FSM SHALL have exactly three states, IDLE, SWEEP and DONE, and all outputs SHALL be registered.
REQ-018 When start=1 and abort=0 in IDLE at edge T, the block SHALL latch all configuration inputs, and at T+1 the state SHALL be SWEEP with phi_inc_o=phi_start, clken_o=1, busy=1 and sweep_trig=1.
REQ-019 Configuration inputs SHALL be ignored outside the IDLE-to-SWEEP transition, so that a mid-run change has no effect.
REQ-020 Step k (k=0..N-1) SHALL drive phi_inc_o = phi_start + k*phi_step modulo 2^PHI_W, accumulated by addition with silent wrap-around.
REQ-021 Each step SHALL last D cycles, where D = dwell, and dwell=0 SHALL be treated as D=1.
REQ-022 A sweep SHALL last exactly N*D cycles, where N = n_steps.
REQ-023 After the last cycle of a sweep, if n_sweeps=0 or sweeps completed < n_sweeps, the next cycle SHALL reload phi_start and pulse sweep_trig, with no gap cycle.
REQ-024 Otherwise the next state SHALL be DONE: done=1, busy=0, clken_o=0, phi_inc_o=0 for one cycle, and then IDLE.
REQ-025 n_steps=0 SHALL go directly from IDLE to DONE, with done pulsed at T+1 and no sweep_trig.
REQ-026 Continuous mode (n_sweeps=0) SHALL end only on abort.
REQ-027 abort=1 in SWEEP or DONE SHALL force IDLE on the next edge with no done pulse, and clken_o=0, phi_inc_o=0, busy=0.
REQ-028 When abort and start are asserted together in IDLE, abort SHALL win and no run SHALL start.
REQ-029 start while busy=1 SHALL be ignored.
REQ-030 In IDLE, phi_inc_o SHALL be 0, clken_o 0, busy 0, sweep_trig 0 and done 0.
REQ-031 The internal sweep counter SHALL be 8 bits and SHALL saturate, not wrap, in continuous mode.

Reset
REQ-032 reset_n=0 SHALL asynchronously force state IDLE, all counters to 0, and phi_inc_o=0, clken_o=0, busy=0, sweep_trig=0, done=0.
REQ-033 Reset deassertion SHALL take effect at the first rising clk edge with reset_n=1.
REQ-034 Reset asserted mid-sweep SHALL discard the run with no done pulse.

Verification
REQ-035 The bench SHALL cover: phi_start=0x0053E2D6, phi_step=0x100, n_steps=4, dwell=2, n_sweeps=1 -> phi_inc_o = 0x0053E2D6 x2, 0x0053E3D6 x2, 0x0053E4D6 x2, 0x0053E5D6 x2; sweep_trig at T+1 only; done at T+9; busy high for 8 cycles.
REQ-036 The bench SHALL cover: n_sweeps=3, n_steps=2, dwell=0 -> sweep_trig at T+1, T+3 and T+5; done at T+7; no gap cycles.
REQ-037 The bench SHALL cover: phi_start=0xFFFFFFF0, phi_step=0x20, n_steps=2, dwell=1 -> phi_inc_o 0xFFFFFFF0 then 0x00000010 (wrap).
REQ-038 The bench SHALL cover: n_sweeps=0 with abort at sweep 5, step 1 -> next cycle IDLE, clken_o=0, and no done pulse.
REQ-039 The bench SHALL cover: start and abort asserted in the same IDLE cycle -> busy stays 0; separately, start pulsed mid-run -> run timing unchanged.
REQ-040 The bench SHALL cover: reset_n pulsed low asynchronously mid-step, between edges -> outputs 0 immediately; after release, start restarts cleanly from phi_start.
